// File: rtl/spi_flash_responder.sv
// SPI flash-read target: READ (0x03) + word address, streams DATA_W-bit words MSB-first with prefetch.
// Define FAST_READ_EN to also accept FAST READ (0x0B) with 8 dummy SCLKs.
module spi_flash_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso_o,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cmd_err
);
    localparam int MAXB  = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                             : ((DATA_W > 8) ? DATA_W : 8);
    localparam int CNT_W = $clog2(MAXB);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, LOAD, DATA, IGNORE
`ifdef FAST_READ_EN
        , DUMMY
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   sclk_q;
    logic                   cs_s, mosi_s, fall;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [6:0]         op_sr, op_nxt;
    logic [ADDR_W-2:0]  addr_sr, addr_nxt;
    logic [DATA_W-2:0]  shift_reg, shift_nxt;
    logic [DATA_W-1:0]  prefetch_buf, pf_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic               mem_rd_nxt, miso_nxt, oe_nxt, cmd_err_nxt;
    logic               rd_q;
    logic [7:0]         opcode;
    logic [ADDR_W-1:0]  addr_full;
`ifdef FAST_READ_EN
    logic               fast, fast_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign fall      = sclk_q & ~sclk_sync[SYNC_STAGES-1];
    assign opcode    = {op_sr, mosi_s};
    assign addr_full = {addr_sr, mosi_s};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            op_sr        <= '0;
            addr_sr      <= '0;
            shift_reg    <= '0;
            prefetch_buf <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            rd_q         <= 1'b0;
            spi_miso_o   <= 1'b0;
            spi_miso_oe  <= 1'b0;
            cmd_err      <= 1'b0;
`ifdef FAST_READ_EN
            fast         <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            op_sr        <= op_nxt;
            addr_sr      <= addr_nxt;
            shift_reg    <= shift_nxt;
            prefetch_buf <= pf_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_rd       <= mem_rd_nxt;
            rd_q         <= mem_rd;
            spi_miso_o   <= miso_nxt;
            spi_miso_oe  <= oe_nxt;
            cmd_err      <= cmd_err_nxt;
`ifdef FAST_READ_EN
            fast         <= fast_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        op_nxt       = op_sr;
        addr_nxt     = addr_sr;
        shift_nxt    = shift_reg;
        pf_nxt       = prefetch_buf;
        mem_addr_nxt = mem_addr;
        mem_rd_nxt   = 1'b0;
        miso_nxt     = spi_miso_o;
        oe_nxt       = spi_miso_oe;
        cmd_err_nxt  = 1'b0;
`ifdef FAST_READ_EN
        fast_nxt     = fast;
`endif
        // cs high overrides everything, including an SCLK edge in the same clk
        if (cs_s) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
            miso_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt   = CMD;
                    bit_cnt_nxt = '0;
`ifdef FAST_READ_EN
                    fast_nxt    = 1'b0;
`endif
                end
                CMD: if (fall) begin
                    op_nxt      = opcode[6:0];
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(7)) begin
                        bit_cnt_nxt = '0;
                        if (opcode == 8'h03) begin
                            state_nxt = ADDR;
`ifdef FAST_READ_EN
                        end else if (opcode == 8'h0B) begin
                            state_nxt = ADDR;
                            fast_nxt  = 1'b1;
`endif
                        end else begin
                            cmd_err_nxt = 1'b1;
                            state_nxt   = IGNORE;
                        end
                    end
                end
                ADDR: if (fall) begin
                    addr_nxt    = addr_full[ADDR_W-2:0];
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(ADDR_W-1)) begin
                        bit_cnt_nxt  = '0;
                        mem_addr_nxt = addr_full;
`ifdef FAST_READ_EN
                        if (fast) begin
                            state_nxt = DUMMY;
                        end else
`endif
                        begin
                            mem_rd_nxt = 1'b1;
                            state_nxt  = LOAD;
                        end
                    end
                end
`ifdef FAST_READ_EN
                DUMMY: if (fall) begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(7)) begin
                        bit_cnt_nxt = '0;
                        mem_rd_nxt  = 1'b1;
                        state_nxt   = LOAD;
                    end
                end
`endif
                // rd_q marks the clk in which mem_rdata answers the previous strobe
                LOAD: if (rd_q) begin
                    shift_nxt    = mem_rdata[DATA_W-2:0];
                    miso_nxt     = mem_rdata[DATA_W-1];
                    oe_nxt       = 1'b1;
                    mem_addr_nxt = mem_addr + ADDR_W'(1);
                    mem_rd_nxt   = 1'b1;
                    bit_cnt_nxt  = '0;
                    state_nxt    = DATA;
                end
                DATA: begin
                    if (rd_q) pf_nxt = mem_rdata;
                    if (fall) begin
                        if (bit_cnt == CNT_W'(DATA_W-1)) begin
                            shift_nxt    = prefetch_buf[DATA_W-2:0];
                            miso_nxt     = prefetch_buf[DATA_W-1];
                            mem_addr_nxt = mem_addr + ADDR_W'(1);
                            mem_rd_nxt   = 1'b1;
                            bit_cnt_nxt  = '0;
                        end else begin
                            shift_nxt   = {shift_reg[DATA_W-3:0], 1'b0};
                            miso_nxt    = shift_reg[DATA_W-2];
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                IGNORE: oe_nxt = 1'b0;
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder; scoreboard queues for MISO bits and mem_rd addresses.
module tb_spi_flash_responder;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SS   = 2;
    localparam int HALF = 100;
    localparam int Q    = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_cs = 1'b1;
    logic          spi_sclk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_miso_o, spi_miso_oe, mem_rd, busy, cmd_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [0:65535];

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    logic          exp_bits[$];
    logic [AW-1:0] rd_exp[$];

    spi_flash_responder #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso_o(spi_miso_o), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mem_rd / cmd_err monitor
    always @(negedge clk) begin
        if (cmd_err) err_cnt++;
        if (mem_rd) begin
            if (rd_exp.size() == 0) begin
                total++; bad++;
                $display("FAIL mem_rd_spurious: got addr %h expected none", mem_addr);
            end else begin
                chk("mem_rd_addr", {16'h0, mem_addr}, {16'h0, rd_exp.pop_front()});
            end
        end
    end

    // MISO monitor: initiator samples on the rising SCLK edge
    always @(posedge spi_sclk) begin
        #1;
        if (spi_miso_oe) begin
            if (exp_bits.size() == 0) begin
                total++; bad++;
                $display("FAIL miso_spurious: got oe=1 bit=%b expected oe=0", spi_miso_o);
            end else begin
                chk("miso_bit", {31'h0, spi_miso_o}, {31'h0, exp_bits.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(w[i]);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            #Q; spi_sclk = 1'b1;
            #HALF; spi_sclk = 1'b0;
            #Q;
        end
    endtask

    // last pulse is left high so cs rises before its falling edge
    task automatic data_clocks(input int n);
        spi_mosi = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            #Q; spi_sclk = 1'b1;
            #HALF; spi_sclk = 1'b0;
            #Q;
        end
        #Q; spi_sclk = 1'b1;
        #HALF;
    endtask

    task automatic cs_begin();
        spi_cs = 1'b0;
        #HALF;
    endtask

    task automatic cs_end(input string tag);
        spi_cs = 1'b1;
        for (int k = 0; k < SS + 1; k++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        chk({tag, "_busy_fall"}, {31'h0, busy}, 32'h0);
        chk({tag, "_oe_off"}, {31'h0, spi_miso_oe}, 32'h0);
        @(negedge clk);
        spi_sclk = 1'b0;
        #HALF;
    endtask

    task automatic end_checks(input string tag, input int exp_err);
        chk({tag, "_rd_left"}, rd_exp.size(), 32'h0);
        chk({tag, "_bits_left"}, exp_bits.size(), 32'h0);
        chk({tag, "_cmd_err"}, err_cnt, exp_err);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[16'h0010] = 16'hA5C3;
        mem[16'hFFFF] = 16'h1234;
        mem[16'h0000] = 16'hBEEF;
        mem[16'h0002] = 16'h3C5A;
        mem[16'h0040] = 16'hF00D;
        mem[16'h0041] = 16'h1357;
        mem[16'h0020] = 16'h8001;

        repeat (3) @(negedge clk);
        chk("rst_miso", {31'h0, spi_miso_o}, 32'h0);
        chk("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
        chk("rst_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, cmd_err}, 32'h0);
        rst_n = 1'b1;
        #HALF;

        // single read of 0x0010
        cs_begin();
        send_bits(32'h03, 8);
        chk("single_busy", {31'h0, busy}, 32'h1);
        rd_exp.push_back(16'h0010); rd_exp.push_back(16'h0011);
        send_bits(32'h0010, 16);
        push_word(16'hA5C3);
        data_clocks(16);
        cs_end("single");
        end_checks("single", 0);

        // streaming across the address wrap
        cs_begin();
        send_bits(32'h03, 8);
        rd_exp.push_back(16'hFFFF); rd_exp.push_back(16'h0000); rd_exp.push_back(16'h0001);
        send_bits(32'hFFFF, 16);
        push_word(16'h1234); push_word(16'hBEEF);
        data_clocks(32);
        cs_end("stream");
        end_checks("stream", 0);

        // unsupported opcode
        cs_begin();
        send_bits(32'h9F, 8);
        send_bits(32'h0, 24);
        chk("badop_oe", {31'h0, spi_miso_oe}, 32'h0);
        cs_end("badop");
        end_checks("badop", 1);

        // abort mid-address, then a full read of 0x0002
        cs_begin();
        send_bits(32'h03, 8);
        send_bits(32'h00, 7);
        cs_end("abort");
        end_checks("abort", 1);
        cs_begin();
        send_bits(32'h03, 8);
        rd_exp.push_back(16'h0002); rd_exp.push_back(16'h0003);
        send_bits(32'h0002, 16);
        push_word(16'h3C5A);
        data_clocks(16);
        cs_end("after_abort");
        end_checks("after_abort", 1);

        // async reset after 5 data bits of 0xF00D
        cs_begin();
        send_bits(32'h03, 8);
        rd_exp.push_back(16'h0040); rd_exp.push_back(16'h0041);
        send_bits(32'h0040, 16);
        for (int i = 15; i >= 11; i--) exp_bits.push_back(mem[16'h0040][i]);
        send_bits(32'h0, 5);
        #Q;
        rst_n = 1'b0;
        #1;
        chk("mrst_oe", {31'h0, spi_miso_oe}, 32'h0);
        chk("mrst_miso", {31'h0, spi_miso_o}, 32'h0);
        chk("mrst_addr", {16'h0, mem_addr}, 32'h0);
        chk("mrst_rd", {31'h0, mem_rd}, 32'h0);
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        spi_cs = 1'b1;
        #HALF;
        @(negedge clk);
        rst_n = 1'b1;
        #HALF;
        end_checks("mrst", 1);
        cs_begin();
        send_bits(32'h03, 8);
        rd_exp.push_back(16'h0041); rd_exp.push_back(16'h0042);
        send_bits(32'h0041, 16);
        push_word(16'h1357);
        data_clocks(16);
        cs_end("post_rst");
        end_checks("post_rst", 1);

        // FAST READ 0x0B at 0x0020
        cs_begin();
        send_bits(32'h0B, 8);
`ifdef FAST_READ_EN
        rd_exp.push_back(16'h0020); rd_exp.push_back(16'h0021);
        send_bits(32'h0020, 16);
        send_bits(32'hFF, 8);
        chk("fast_dummy_oe", {31'h0, spi_miso_oe}, 32'h0);
        push_word(16'h8001);
        data_clocks(16);
        cs_end("fast");
        end_checks("fast", 1);
`else
        send_bits(32'h0020, 16);
        send_bits(32'hFF, 8);
        chk("fast_off_oe", {31'h0, spi_miso_oe}, 32'h0);
        cs_end("fast_off");
        end_checks("fast_off", 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
